// File: rtl/exe_mc_if.sv
// Handshake/bus bundle of the exe_mc execute stage: id_exe side (names ending _i into the stage)
// and exe_mem side, plus flush and busy status. Signal names are from the stage's point of view.
interface exe_mc_if #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int ALUOP_W = 5
);
    logic               flush_i;
    logic               valid_i;
    logic               ready_o;
    logic [XLEN-1:0]    op1_i;
    logic [XLEN-1:0]    op2_i;
    logic               reg_we_i;
    logic [RADDR_W-1:0] reg_waddr_i;
    logic [ALUOP_W-1:0] aluOp_i;
    logic               valid_o;
    logic               ready_i;
    logic [RADDR_W-1:0] reg_waddr_o;
    logic               reg_we_o;
    logic [XLEN-1:0]    reg_wdata_o;
    logic               busy_o;

    modport slave (
        input  flush_i, valid_i, op1_i, op2_i, reg_we_i, reg_waddr_i, aluOp_i, ready_i,
        output ready_o, valid_o, reg_waddr_o, reg_we_o, reg_wdata_o, busy_o
    );

    modport master (
        output flush_i, valid_i, op1_i, op2_i, reg_we_i, reg_waddr_i, aluOp_i, ready_i,
        input  ready_o, valid_o, reg_waddr_o, reg_we_o, reg_wdata_o, busy_o
    );
endinterface

// File: rtl/exe_mc.sv
// Registered execute stage: single-cycle integer ALU plus, when EXE_MULDIV_EN is defined, an iterative
// radix-2 multiply/divide unit. Without EXE_MULDIV_EN the mul/div codes are treated as illegal (bubbles).
module exe_mc #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int ALUOP_W = 5
) (
    input  logic    clk_i,
    input  logic    rst_i,
    exe_mc_if.slave bus
);
    localparam int SHW = $clog2(XLEN);

    localparam logic [ALUOP_W-1:0] OP_OR   = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] OP_AND  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] OP_XOR  = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] OP_ADD  = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] OP_SUB  = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] OP_SLL  = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] OP_SRL  = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] OP_SRA  = ALUOP_W'(8);
    localparam logic [ALUOP_W-1:0] OP_SLT  = ALUOP_W'(9);
    localparam logic [ALUOP_W-1:0] OP_SLTU = ALUOP_W'(10);

    logic               accept;
    logic               out_free;
    logic               load_alu;
    logic               alu_ok;
    logic [XLEN-1:0]    alu_res;
    logic [SHW-1:0]     shamt;

    logic               valid_q, valid_d;
    logic               we_q, we_d;
    logic [RADDR_W-1:0] waddr_q, waddr_d;
    logic [XLEN-1:0]    wdata_q, wdata_d;

    assign shamt    = bus.op2_i[SHW-1:0];
    assign out_free = ~valid_q | bus.ready_i;
    assign accept   = bus.valid_i & bus.ready_o;

    always_comb begin
        alu_res = '0;
        alu_ok  = 1'b1;
        case (bus.aluOp_i)
            OP_OR:   alu_res = bus.op1_i | bus.op2_i;
            OP_AND:  alu_res = bus.op1_i & bus.op2_i;
            OP_XOR:  alu_res = bus.op1_i ^ bus.op2_i;
            OP_ADD:  alu_res = bus.op1_i + bus.op2_i;
            OP_SUB:  alu_res = bus.op1_i - bus.op2_i;
            OP_SLL:  alu_res = bus.op1_i << shamt;
            OP_SRL:  alu_res = bus.op1_i >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(bus.op1_i) >>> shamt);
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.op1_i) < $signed(bus.op2_i))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (bus.op1_i < bus.op2_i)};
            // NOP, illegal codes and the multi-cycle codes never take the single-cycle path
            default: alu_ok  = 1'b0;
        endcase
    end

`ifdef EXE_MULDIV_EN
    localparam int CNT_W = $clog2(XLEN);

    localparam logic [ALUOP_W-1:0] OP_MUL   = ALUOP_W'(11);
    localparam logic [ALUOP_W-1:0] OP_MULH  = ALUOP_W'(12);
    localparam logic [ALUOP_W-1:0] OP_MULHU = ALUOP_W'(13);
    localparam logic [ALUOP_W-1:0] OP_DIV   = ALUOP_W'(14);
    localparam logic [ALUOP_W-1:0] OP_DIVU  = ALUOP_W'(15);
    localparam logic [ALUOP_W-1:0] OP_REM   = ALUOP_W'(16);
    localparam logic [ALUOP_W-1:0] OP_REMU  = ALUOP_W'(17);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]    hi_q, hi_d;
    logic [XLEN-1:0]    lo_q, lo_d;
    logic [XLEN-1:0]    opb_q, opb_d;
    logic [XLEN-1:0]    op1_q, op1_d;
    logic [ALUOP_W-1:0] mop_q, mop_d;
    logic [RADDR_W-1:0] mwaddr_q, mwaddr_d;
    logic               mwe_q, mwe_d;
    logic               neg_q, neg_d;
    logic               dz_q, dz_d;
    logic               ovf_q, ovf_d;

    logic               is_md;
    logic               md_signed;
    logic               s1, s2;
    logic               is_mul_q;
    logic               md_load;
    logic               div_ge;
    logic [XLEN-1:0]    mag1, mag2;
    logic [XLEN-1:0]    md_res;
    logic [XLEN:0]      mul_sum;
    logic [XLEN:0]      div_shift;
    logic [2*XLEN-1:0]  prod;

    assign is_md     = (bus.aluOp_i >= OP_MUL) && (bus.aluOp_i <= OP_REMU);
    assign md_signed = (bus.aluOp_i == OP_MULH) || (bus.aluOp_i == OP_DIV) || (bus.aluOp_i == OP_REM);
    assign s1        = md_signed & bus.op1_i[XLEN-1];
    assign s2        = md_signed & bus.op2_i[XLEN-1];
    assign mag1      = s1 ? -bus.op1_i : bus.op1_i;
    assign mag2      = s2 ? -bus.op2_i : bus.op2_i;
    assign is_mul_q  = (mop_q <= OP_MULHU);

    // {hi,lo} is the shift-add product register; for divide hi is the partial remainder, lo the quotient
    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
    assign div_shift = {hi_q, lo_q[XLEN-1]};
    assign div_ge    = (div_shift >= {1'b0, opb_q});
    assign prod      = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    assign md_load   = (state_q == S_DONE) & out_free & ~bus.flush_i;

    assign load_alu    = accept & ~is_md;
    assign bus.busy_o  = (state_q != S_IDLE);
    assign bus.ready_o = (state_q == S_IDLE) & out_free & ~rst_i & ~bus.flush_i;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opb_d    = opb_q;
        op1_d    = op1_q;
        mop_d    = mop_q;
        mwaddr_d = mwaddr_q;
        mwe_d    = mwe_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        if (bus.flush_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept && is_md) begin
                        state_d  = S_BUSY;
                        cnt_d    = '0;
                        hi_d     = '0;
                        lo_d     = mag1;
                        opb_d    = mag2;
                        op1_d    = bus.op1_i;
                        mop_d    = bus.aluOp_i;
                        mwaddr_d = bus.reg_waddr_i;
                        mwe_d    = bus.reg_we_i & (|bus.reg_waddr_i);
                        neg_d    = (bus.aluOp_i == OP_REM) ? s1 : (s1 ^ s2);
                        dz_d     = ~|bus.op2_i;
                        ovf_d    = md_signed & (bus.op1_i == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.op2_i);
                    end
                end
                S_BUSY: begin
                    if (is_mul_q) begin
                        hi_d = mul_sum[XLEN:1];
                        lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
                    end else if (div_ge) begin
                        hi_d = div_shift[XLEN-1:0] - opb_q;
                        lo_d = {lo_q[XLEN-2:0], 1'b1};
                    end else begin
                        hi_d = div_shift[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(XLEN-1)) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_free) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Sign fix-up and the divide corner cases are resolved only here, keeping the latency fixed
    always_comb begin
        md_res = '0;
        case (mop_q)
            OP_MUL:            md_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHU: md_res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:   md_res = dz_q ? '1 : (ovf_q ? op1_q : (neg_q ? -lo_q : lo_q));
            default:           md_res = dz_q ? op1_q : (ovf_q ? '0 : (neg_q ? -hi_q : hi_q));
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
            op1_q    <= '0;
            mop_q    <= '0;
            mwaddr_q <= '0;
            mwe_q    <= 1'b0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opb_q    <= opb_d;
            op1_q    <= op1_d;
            mop_q    <= mop_d;
            mwaddr_q <= mwaddr_d;
            mwe_q    <= mwe_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
        end
    end
`else
    assign load_alu    = accept;
    assign bus.busy_o  = 1'b0;
    assign bus.ready_o = out_free & ~rst_i & ~bus.flush_i;
`endif

    always_comb begin
        valid_d = valid_q;
        we_d    = we_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (bus.flush_i) begin
            valid_d = 1'b0;
            we_d    = 1'b0;
            waddr_d = '0;
            wdata_d = '0;
        end else if (load_alu) begin
            valid_d = 1'b1;
            we_d    = alu_ok & bus.reg_we_i & (|bus.reg_waddr_i);
            waddr_d = alu_ok ? bus.reg_waddr_i : '0;
            wdata_d = alu_ok ? alu_res : '0;
`ifdef EXE_MULDIV_EN
        end else if (md_load) begin
            valid_d = 1'b1;
            we_d    = mwe_q;
            waddr_d = mwaddr_q;
            wdata_d = md_res;
`endif
        end else if (valid_q && bus.ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            valid_q <= valid_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.valid_o     = valid_q;
    assign bus.reg_we_o    = we_q;
    assign bus.reg_waddr_o = waddr_q;
    assign bus.reg_wdata_o = wdata_q;
endmodule

// File: tb/tb_exe_mc.sv
// Self-checking bench for exe_mc: directed corner cases, then randomized traffic against a
// behavioural slot/latency model. Mul/div expectations follow EXE_MULDIV_EN.
module tb_exe_mc;
    localparam int XLEN = 32;
`ifdef EXE_MULDIV_EN
    localparam int MD_LAT = XLEN + 2;
`else
    localparam int MD_LAT = 1;
`endif

    typedef struct packed {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_mis = 0;

    always #5 clk = ~clk;

    exe_mc_if #(.XLEN(XLEN), .RADDR_W(5), .ALUOP_W(5)) bus ();

    exe_mc #(.XLEN(XLEN), .RADDR_W(5), .ALUOP_W(5)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wa, input logic we);
        bus.valid_i     = 1'b1;
        bus.aluOp_i     = op;
        bus.op1_i       = a;
        bus.op2_i       = b;
        bus.reg_waddr_i = wa;
        bus.reg_we_i    = we;
    endtask

    function automatic logic is_md_op(input logic [4:0] op);
`ifdef EXE_MULDIV_EN
        return (op >= 5'd11) && (op <= 5'd17);
`else
        return 1'b0;
`endif
    endfunction

    function automatic res_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic we, input logic [4:0] wa);
        res_t        r;
        logic        ok;
        logic [31:0] d;
        longint      sp;
        logic [63:0] up;
        ok = 1'b1;
        d  = '0;
        case (op)
            5'd1:  d = a | b;
            5'd2:  d = a & b;
            5'd3:  d = a ^ b;
            5'd4:  d = a + b;
            5'd5:  d = a - b;
            5'd6:  d = a << b[4:0];
            5'd7:  d = a >> b[4:0];
            5'd8:  d = $signed(a) >>> b[4:0];
            5'd9:  d = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd10: d = (a < b) ? 32'd1 : 32'd0;
`ifdef EXE_MULDIV_EN
            5'd11: d = a * b;
            5'd12: begin sp = longint'($signed(a)) * longint'($signed(b)); d = sp[63:32]; end
            5'd13: begin up = {32'd0, a} * {32'd0, b}; d = up[63:32]; end
            5'd14: d = (b == 0) ? 32'hFFFF_FFFF :
                       (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : $signed(a) / $signed(b);
            5'd15: d = (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'd16: d = (b == 0) ? a :
                       (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : $signed(a) % $signed(b);
            5'd17: d = (b == 0) ? a : a % b;
`endif
            default: ok = 1'b0;
        endcase
        r.we = ok & we & (wa != 5'd0);
        r.wa = ok ? wa : 5'd0;
        r.wd = ok ? d : 32'd0;
        return r;
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom % 6)
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // One op through the stage with ready_i held high; measures accept->valid_o latency
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] wa, input logic [31:0] exp_wd, input logic exp_we,
                          input logic [4:0] exp_wa, input int exp_lat);
        int lat;
        tick();
        drive(op, a, b, wa, 1'b1);
        bus.ready_i = 1'b1;
        @(negedge clk);
        chk({tag, "_rdy"}, bus.ready_o, 1'b1);
        tick();
        bus.valid_i = 1'b0;
        lat = 1;
        @(negedge clk);
        while (bus.valid_o !== 1'b1 && lat < 100) begin
            if (lat == 10) begin
                chk({tag, "_busy"}, bus.busy_o, 1'b1);
                chk({tag, "_stall"}, bus.ready_o, 1'b0);
            end
            tick();
            lat++;
            @(negedge clk);
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_wd"}, bus.reg_wdata_o, exp_wd);
        chk({tag, "_we"}, bus.reg_we_o, exp_we);
        chk({tag, "_wa"}, bus.reg_waddr_o, exp_wa);
        $display("op %s: aluOp=%0d a=0x%h b=0x%h -> wdata=0x%h lat=%0d", tag, op, a, b, bus.reg_wdata_o, lat);
    endtask

    res_t        slot, md_res, got;
    logic        slot_full, md_active, exp_ready, free;
    int          md_left;
    logic [4:0]  rop;

    initial begin
        rst = 1'b1;
        bus.flush_i = 1'b0;
        bus.ready_i = 1'b1;
        drive(5'd4, 32'd1, 32'd2, 5'd1, 1'b1);

        // reset held two cycles with valid_i high
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", bus.ready_o, 1'b0);
        chk("rst_valid", bus.valid_o, 1'b0);
        chk("rst_we", bus.reg_we_o, 1'b0);
        chk("rst_wa", bus.reg_waddr_o, 5'd0);
        chk("rst_wd", bus.reg_wdata_o, 32'd0);
        chk("rst_busy", bus.busy_o, 1'b0);

        // ADD wrap then SRA back-to-back
        tick();
        rst = 1'b0;
        drive(5'd4, 32'h7FFF_FFFF, 32'd1, 5'd3, 1'b1);
        @(negedge clk);
        chk("add_rdy", bus.ready_o, 1'b1);
        tick();
        drive(5'd8, 32'h8000_0000, 32'd4, 5'd4, 1'b1);
        @(negedge clk);
        chk("add_valid", bus.valid_o, 1'b1);
        chk("add_wd", bus.reg_wdata_o, 32'h8000_0000);
        chk("add_wa", bus.reg_waddr_o, 5'd3);
        chk("add_we", bus.reg_we_o, 1'b1);
        chk("sra_rdy", bus.ready_o, 1'b1);
        tick();
        bus.valid_i = 1'b0;
        @(negedge clk);
        chk("sra_valid", bus.valid_o, 1'b1);
        chk("sra_wd", bus.reg_wdata_o, 32'hF800_0000);
        $display("op add/sra: wdata=0x%h", bus.reg_wdata_o);

        // back-pressure: OR result held while ready_i low, queued XOR accepted on release
        tick();
        drive(5'd1, 32'hF0, 32'h0F, 5'd6, 1'b1);
        tick();
        drive(5'd3, 32'd5, 32'd3, 5'd7, 1'b1);
        bus.ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("bp_valid", bus.valid_o, 1'b1);
            chk("bp_wd", bus.reg_wdata_o, 32'hFF);
            chk("bp_wa", bus.reg_waddr_o, 5'd6);
            chk("bp_rdy", bus.ready_o, 1'b0);
            tick();
        end
        bus.ready_i = 1'b1;
        @(negedge clk);
        chk("bp_release_rdy", bus.ready_o, 1'b1);
        tick();
        bus.valid_i = 1'b0;
        @(negedge clk);
        chk("bp_xor_wd", bus.reg_wdata_o, 32'd6);
        chk("bp_xor_wa", bus.reg_waddr_o, 5'd7);
        $display("op or/xor backpressure: wdata=0x%h", bus.reg_wdata_o);

        // x0 destination, NOP and illegal codes
        run_op("x0", 5'd4, 32'd5, 32'd6, 5'd0, 32'd11, 1'b0, 5'd0, 1);
        run_op("nop", 5'd0, 32'd1, 32'd2, 5'd4, 32'd0, 1'b0, 5'd0, 1);
        run_op("illegal", 5'd25, 32'd1, 32'd2, 5'd4, 32'd0, 1'b0, 5'd0, 1);
        run_op("sltu", 5'd10, 32'd1, 32'hFFFF_FFFF, 5'd2, 32'd1, 1'b1, 5'd2, 1);
        run_op("slt", 5'd9, 32'd1, 32'hFFFF_FFFF, 5'd2, 32'd0, 1'b1, 5'd2, 1);

`ifdef EXE_MULDIV_EN
        run_op("div_by0", 5'd14, 32'd7, 32'd0, 5'd5, 32'hFFFF_FFFF, 1'b1, 5'd5, MD_LAT);
        run_op("rem_by0", 5'd16, 32'd7, 32'd0, 5'd5, 32'd7, 1'b1, 5'd5, MD_LAT);
        run_op("div_ovf", 5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 32'h8000_0000, 1'b1, 5'd5, MD_LAT);
        run_op("mulhu", 5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFE, 1'b1, 5'd5, MD_LAT);
        run_op("mul", 5'd11, 32'd3, 32'd4, 5'd5, 32'd12, 1'b1, 5'd5, MD_LAT);
        run_op("mulh_neg", 5'd12, 32'hFFFF_FFFE, 32'd3, 5'd5, 32'hFFFF_FFFF, 1'b1, 5'd5, MD_LAT);
        run_op("div_neg", 5'd14, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 1'b1, 5'd5, MD_LAT);
        run_op("rem_neg", 5'd16, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFF, 1'b1, 5'd5, MD_LAT);
`else
        run_op("mul_bubble", 5'd11, 32'd3, 32'd4, 5'd5, 32'd0, 1'b0, 5'd0, MD_LAT);
        run_op("rem_bubble", 5'd16, 32'd7, 32'd0, 5'd5, 32'd0, 1'b0, 5'd0, MD_LAT);
`endif

        // flush at cycle 10 of DIVU 100/7, concurrent valid_i and ready_i must be ignored
        tick();
        drive(5'd15, 32'd100, 32'd7, 5'd8, 1'b1);
        bus.ready_i = 1'b1;
        tick();
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b0;
        repeat (9) tick();
        bus.flush_i = 1'b1;
        bus.ready_i = 1'b1;
        drive(5'd4, 32'd9, 32'd9, 5'd10, 1'b1);
        @(negedge clk);
        chk("flush_rdy", bus.ready_o, 1'b0);
        tick();
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        @(negedge clk);
        chk("flush_busy", bus.busy_o, 1'b0);
        chk("flush_valid", bus.valid_o, 1'b0);
        chk("flush_we", bus.reg_we_o, 1'b0);
        run_op("post_flush_add", 5'd4, 32'd1, 32'd2, 5'd9, 32'd3, 1'b1, 5'd9, 1);

        // reset in the middle of a DIVU
        tick();
        drive(5'd15, 32'd100, 32'd7, 5'd8, 1'b1);
        tick();
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_rdy", bus.ready_o, 1'b0);
        tick();
        rst = 1'b0;
        bus.ready_i = 1'b1;
        @(negedge clk);
        chk("midrst_busy", bus.busy_o, 1'b0);
        chk("midrst_valid", bus.valid_o, 1'b0);
        chk("midrst_wd", bus.reg_wdata_o, 32'd0);

        // randomized traffic against the slot/latency model
        tick();
        slot      = '0;
        slot_full = 1'b0;
        md_active = 1'b0;
        md_left   = 0;
        md_res    = '0;
        for (int c = 0; c < 3000; c++) begin
            rop = ($urandom % 4 == 0) ? 5'(11 + $urandom % 7) : 5'($urandom % 32);
            drive(rop, pick_val(), pick_val(), 5'($urandom % 32), 1'($urandom % 2));
            bus.valid_i = ($urandom % 3) != 0;
            bus.ready_i = ($urandom % 4) != 0;
            bus.flush_i = ($urandom % 64) == 0;
            @(negedge clk);
            exp_ready = !bus.flush_i && !md_active && (!slot_full || bus.ready_i);
            chk("rnd_ready", bus.ready_o, exp_ready);
            chk("rnd_valid", bus.valid_o, slot_full);
            chk("rnd_busy", bus.busy_o, md_active);
            if (slot_full) begin
                got = {bus.reg_we_o, bus.reg_waddr_o, bus.reg_wdata_o};
                chk("rnd_out", got, slot);
                if (bus.ready_i && !bus.flush_i)
                    $display("rnd consume cyc=%0d we=%0b wa=%0d wd=0x%h", c, got.we, got.wa, got.wd);
            end
            if (bus.flush_i) begin
                slot_full = 1'b0;
                md_active = 1'b0;
            end else begin
                free = !slot_full || bus.ready_i;
                if (slot_full && bus.ready_i) slot_full = 1'b0;
                if (md_active) begin
                    if (md_left > 0) begin
                        md_left--;
                    end else if (free) begin
                        slot      = md_res;
                        slot_full = 1'b1;
                        md_active = 1'b0;
                    end
                end else if (bus.valid_i && exp_ready) begin
                    if (is_md_op(rop)) begin
                        md_active = 1'b1;
                        md_left   = XLEN;
                        md_res    = model(rop, bus.op1_i, bus.op2_i, bus.reg_we_i, bus.reg_waddr_i);
                    end else begin
                        slot      = model(rop, bus.op1_i, bus.op2_i, bus.reg_we_i, bus.reg_waddr_i);
                        slot_full = 1'b1;
                    end
                end
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
